// File: rtl/timer_control.sv
// Front-end control for the minutes/seconds timer: button conditioning, mode FSM,
// and increment-pulse stretching toward the slow-clocked counter block.
module timer_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned INC_HOLD        = 100_000_001,
    parameter int unsigned ALARM_CYCLES    = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dir,
    input  logic       finish,
    output logic       enable,
    output logic       forward,
    output logic       incrementSeconds,
    output logic       incrementMinutes,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(INC_HOLD + 1);
    localparam int unsigned AlmW  = $clog2(ALARM_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetSec = 3'd1,
        StSetMin = 3'd2,
        StRun    = 3'd3,
        StPause  = 3'd4,
        StAlarm  = 3'd5
    } state_e;

    // Button bit order: 0 start, 1 mode, 2 up, 3 dir.
    logic [3:0]     btn_raw;
    logic [3:0]     btn_s1_q, btn_s2_q;
    logic [3:0]     db_q, db_prev_q, press_q;
    logic [DbW-1:0] db_cnt_q [4];
    logic           fin_s1_q, fin_s2_q, fin_prev_q;
    logic           finish_evt;

    state_e           state_q, state_d;
    logic             forward_q, forward_d;
    logic             inc_sec_q, inc_min_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [AlmW-1:0]  alarm_cnt_q;
    logic             fire_sec, fire_min, stretching;
    logic             ev_start, ev_mode, ev_up, ev_dir, any_btn;

    assign btn_raw    = {btn_dir, btn_up, btn_mode, btn_start};
    assign finish_evt = fin_s2_q & ~fin_prev_q;
    assign stretching = inc_sec_q | inc_min_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            db_q       <= '0;
            db_prev_q  <= '0;
            press_q    <= '0;
            fin_s1_q   <= 1'b0;
            fin_s2_q   <= 1'b0;
            fin_prev_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            db_prev_q  <= db_q;
            press_q    <= db_q & ~db_prev_q;
            fin_s1_q   <= finish;
            fin_s2_q   <= fin_s1_q;
            fin_prev_q <= fin_s2_q;
            // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            for (int i = 0; i < 4; i++) begin
                if (btn_s2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
                    db_q[i]     <= btn_s2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        forward_d = forward_q;
        fire_sec  = 1'b0;
        fire_min  = 1'b0;
        // Only the highest-priority press in a cycle acts.
        ev_start  = press_q[0];
        ev_mode   = press_q[1] & ~press_q[0];
        ev_up     = press_q[2] & ~(|press_q[1:0]);
        ev_dir    = press_q[3] & ~(|press_q[2:0]);
        any_btn   = |press_q;
        case (state_q)
            StIdle: begin
                if (ev_start)     state_d = StRun;
                else if (ev_mode) state_d = StSetSec;
                else if (ev_dir)  forward_d = ~forward_q;
            end
            StSetSec: begin
                if (ev_start)                  state_d = StRun;
                else if (ev_mode)              state_d = StSetMin;
                else if (ev_up && !stretching) fire_sec = 1'b1;
            end
            StSetMin: begin
                if (ev_start)                  state_d = StRun;
                else if (ev_mode)              state_d = StIdle;
                else if (ev_up && !stretching) fire_min = 1'b1;
            end
            StRun: begin
                if (finish_evt)    state_d = StAlarm;
                else if (ev_start) state_d = StPause;
            end
            StPause: begin
                if (ev_start)     state_d = StRun;
                else if (ev_mode) state_d = StIdle;
            end
            StAlarm: begin
                if (any_btn || alarm_cnt_q == AlmW'(ALARM_CYCLES - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            forward_q   <= 1'b1;
            inc_sec_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            hold_cnt_q  <= '0;
            alarm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            forward_q <= forward_d;
            if (fire_sec || fire_min) begin
                inc_sec_q  <= fire_sec;
                inc_min_q  <= fire_min;
                hold_cnt_q <= HoldW'(1);
            end else if (stretching) begin
                if (hold_cnt_q == HoldW'(INC_HOLD)) begin
                    inc_sec_q  <= 1'b0;
                    inc_min_q  <= 1'b0;
                    hold_cnt_q <= '0;
                end else begin
                    hold_cnt_q <= hold_cnt_q + HoldW'(1);
                end
            end
            if (state_q != StAlarm) begin
                alarm_cnt_q <= '0;
            end else if (alarm_cnt_q != AlmW'(ALARM_CYCLES)) begin
                alarm_cnt_q <= alarm_cnt_q + AlmW'(1);
            end
        end
    end

    assign enable           = (state_q == StRun);
    assign alarm            = (state_q == StAlarm);
    assign forward          = forward_q;
    assign incrementSeconds = inc_sec_q;
    assign incrementMinutes = inc_min_q;
    assign state            = state_q;

endmodule
